ntt_coef_server: RTL and testbench
==================================

NTT_COEF_SERVER -- requirements
Module: ntt_coef_server

Interface
REQ-001 Parameter LOGQ, default 64: coefficient width in bits.
REQ-002 Parameter LOGN, default 4: log2 of the transform size N; N=2**LOGN.
REQ-003 Parameter DELAY_BRAM, default 1: read latency in cycles, legal values 1 or 2.
REQ-004 Local AW=((LOGN<9)?9:LOGN)+1 SHALL be the NTT address width; only bits [LOGN-2:0] index memory.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 go  in  1  single-cycle request to start load/run/unload sequence.
REQ-008 ld_valid, ld_data  in  1, LOGQ  host load stream, natural coefficient order.
REQ-009 ld_ready  out  1  load beat accepted when ld_valid&ld_ready.
REQ-010 ul_valid, ul_data  out  1, LOGQ  result stream, natural order; ul_ready  in  1.
REQ-011 busy  out  1  high in any state except IDLE; done  out  1  one-cycle completion pulse.
REQ-012 ntt_start  out  1; ntt_finish  in  1  run handshake with NTT engine.
REQ-013 ntt_read_address, ntt_write_address  in  AW each; ntt_wea  in  1.
REQ-014 ntt_din_0, ntt_din_1  out  LOGQ  read data to engine; ntt_dout_0, ntt_dout_1  in  LOGQ  write data from engine.
REQ-015 err  out  1  sticky protocol-violation flag (see Configuration).

Function
REQ-016 Storage SHALL be two banks of N/2 words: bank0 holds index k<N/2, bank1 holds index k+N/2.
REQ-017 FSM states IDLE, LOAD, RUN, UNLOAD; go in IDLE -> LOAD; go in any other state SHALL be ignored.
REQ-018 LOAD: ld_ready=1; beat counter k 0..N-1 writes bank0[k] or bank1[k-N/2]; accepting beat N-1 -> RUN.
REQ-019 RUN: ntt_start SHALL be held high from RUN entry until the cycle after a rising edge of ntt_finish is sampled, then -> UNLOAD.
REQ-020 ntt_finish already high on RUN entry SHALL NOT count; a fresh 0->1 edge is required.
REQ-021 Read port: ntt_din_0=bank0[ra], ntt_din_1=bank1[ra], ra=ntt_read_address[LOGN-2:0], valid exactly DELAY_BRAM cycles after address presented, in every state.
REQ-022 Write port: in RUN with ntt_wea=1, bank0[wa]<=ntt_dout_0 and bank1[wa]<=ntt_dout_1; ntt_wea outside RUN SHALL be ignored.
REQ-023 Same-cycle read and write to the same address SHALL return the old (pre-write) data.
REQ-024 UNLOAD: ul_data presents index j=0..N-1 in natural order; ul_valid held with stable data until ul_ready; after beat N-1 accepted -> IDLE with done=1 for exactly one cycle.
REQ-025 ld_ready=0 outside LOAD; ul_valid=0 outside UNLOAD; ld_valid outside LOAD SHALL have no effect on storage.
REQ-026 Counters SHALL be LOGN bits wide and never wrap within a state; upper address bits above LOGN-2 SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counters 0, ld_ready=0, ul_valid=0, ntt_start=0, busy=0, done=0, err=0, ntt_din_0/1=0.
REQ-028 Reset mid-LOAD/RUN/UNLOAD SHALL abort the sequence; memory contents are not cleared and are undefined to the host.

Configuration
REQ-029 Macro NTT_COEF_SERVER_CHECK_EN defined: err SHALL set and stay set until reset on ntt_wea outside RUN, ld_valid outside LOAD/IDLE, or ntt_finish edge outside RUN.
REQ-030 Macro undefined: checker SHALL be absent and err tied to 0; all other behaviour identical.

Verification
REQ-031 Reset, go, load 0..15 (LOGN=4), engine stub writes x+1 at every address, finish -> unload returns 1..16, done pulses once.
REQ-032 DELAY_BRAM=1 and 2: after load, drive read_address 0..7 -> ntt_din_0=k, ntt_din_1=k+8 exactly 1 or 2 cycles later.
REQ-033 Same-cycle read and write address 3, write 0xAAAA -> read returns 3, next read of 3 returns 0xAAAA.
REQ-034 Random ul_ready back-pressure (50%) -> 16 beats, each held stable until accepted, order preserved.
REQ-035 rst_n pulsed low mid-RUN -> ntt_start, busy drop asynchronously; subsequent go completes normally.
REQ-036 With NTT_COEF_SERVER_CHECK_EN, ntt_wea pulsed in IDLE -> err=1 and remains 1 until reset; memory unchanged.

Source files
------------

// File: rtl/ntt_coef_server.sv
// ntt_coef_server: coefficient buffer that loads N words from a host, serves them to an NTT engine, and streams the results back
// Ports: clk, rst_n (async, active low); go starts a load/run/unload sequence;
//   ld_valid/ld_data/ld_ready host load stream, natural order;
//   ul_valid/ul_data/ul_ready result stream, natural order;
//   busy (not idle), done (one-cycle completion pulse);
//   ntt_start/ntt_finish engine run handshake;
//   ntt_read_address -> ntt_din_0/1 (DELAY_BRAM cycles later);
//   ntt_write_address/ntt_wea/ntt_dout_0/1 engine write port;
//   err sticky protocol-violation flag, active only with NTT_COEF_SERVER_CHECK_EN defined
module ntt_coef_server #(
  parameter int LOGQ = 64,
  parameter int LOGN = 4,
  parameter int DELAY_BRAM = 1,
  localparam int AW = ((LOGN < 9) ? 9 : LOGN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic            ld_valid,
  input  logic [LOGQ-1:0] ld_data,
  output logic            ld_ready,
  output logic            ul_valid,
  output logic [LOGQ-1:0] ul_data,
  input  logic            ul_ready,
  output logic            busy,
  output logic            done,
  output logic            ntt_start,
  input  logic            ntt_finish,
  input  logic [AW-1:0]   ntt_read_address,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic            ntt_wea,
  output logic [LOGQ-1:0] ntt_din_0,
  output logic [LOGQ-1:0] ntt_din_1,
  input  logic [LOGQ-1:0] ntt_dout_0,
  input  logic [LOGQ-1:0] ntt_dout_1,
  output logic            err
);
  localparam int H = 2 ** (LOGN - 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;
  state_t state;
  logic [LOGN-1:0] k, j;
  logic fin_q, fin_rise;
  logic [LOGQ-1:0] bank0 [H];
  logic [LOGQ-1:0] bank1 [H];
  logic [LOGQ-1:0] rd0, rd1;
  logic [LOGN-2:0] ra, wa;
  logic unused;
  assign ra = ntt_read_address[LOGN-2:0];
  assign wa = ntt_write_address[LOGN-2:0];
  assign unused = ^{ntt_read_address[AW-1:LOGN-1], ntt_write_address[AW-1:LOGN-1]};
  assign fin_rise = ntt_finish & ~fin_q;
  assign ld_ready = state == LOAD;
  assign ul_valid = state == UNLOAD;
  assign ntt_start = state == RUN;
  assign busy = state != IDLE;
  // top counter bit selects the bank, the rest index within it
  assign ul_data = j[LOGN-1] ? bank1[j[LOGN-2:0]] : bank0[j[LOGN-2:0]];
  always_ff @(posedge clk) begin
    if (ld_ready && ld_valid) begin
      if (k[LOGN-1]) bank1[k[LOGN-2:0]] <= ld_data;
      else bank0[k[LOGN-2:0]] <= ld_data;
    end
    if (state == RUN && ntt_wea) begin
      bank0[wa] <= ntt_dout_0;
      bank1[wa] <= ntt_dout_1;
    end
  end
  // non-blocking write above gives read-before-write on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rd0 <= bank0[ra];
      rd1 <= bank1[ra];
    end
  end
  generate
    if (DELAY_BRAM == 2) begin : g_d2
      logic [LOGQ-1:0] q0, q1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q0 <= '0;
          q1 <= '0;
        end else begin
          q0 <= rd0;
          q1 <= rd1;
        end
      end
      assign ntt_din_0 = q0;
      assign ntt_din_1 = q1;
    end else begin : g_d1
      assign ntt_din_0 = rd0;
      assign ntt_din_1 = rd1;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      fin_q <= 1'b0;
      done <= 1'b0;
    end else begin
      fin_q <= ntt_finish;
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= LOAD;
          k <= '0;
        end
        LOAD: if (ld_valid) begin
          k <= k + 1'b1;
          if (&k) state <= RUN;
        end
        RUN: if (fin_rise) begin
          state <= UNLOAD;
          j <= '0;
        end
        UNLOAD: if (ul_ready) begin
          j <= j + 1'b1;
          if (&j) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef NTT_COEF_SERVER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((ntt_wea && state != RUN) || (ld_valid && (state == RUN || state == UNLOAD)) ||
             (fin_rise && state != RUN)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ntt_coef_server.sv
// tb_ntt_coef_server: checks two ntt_coef_server instances (read latency 1 and 2) against a coefficient-array model
module tb_ntt_coef_server;
  localparam int Q = 64, LN = 4, N = 16, H = 8, AW = 10;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_UNLOAD = 3;
`ifdef NTT_COEF_SERVER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, ld_valid = 1'b0, ul_ready = 1'b0;
  logic ntt_finish = 1'b0, ntt_wea = 1'b0;
  logic [Q-1:0] ld_data = '0, dout0 = '0, dout1 = '0;
  logic [AW-1:0] raddr = '0, waddr = '0;
  logic ld_ready [2], ul_valid [2], busy [2], done [2], start [2], err [2];
  logic [Q-1:0] ul_data [2], din0 [2], din1 [2];
  int cmp = 0, mis = 0, done_cnt = 0;
  logic [63:0] got [$];
  always #5 clk = ~clk;
  for (genvar d = 0; d < 2; d++) begin : g_dut
    ntt_coef_server #(.LOGQ(Q), .LOGN(LN), .DELAY_BRAM(d + 1)) u (
      .clk(clk), .rst_n(rst_n), .go(go), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready[d]), .ul_valid(ul_valid[d]), .ul_data(ul_data[d]), .ul_ready(ul_ready),
      .busy(busy[d]), .done(done[d]), .ntt_start(start[d]), .ntt_finish(ntt_finish),
      .ntt_read_address(raddr), .ntt_write_address(waddr), .ntt_wea(ntt_wea),
      .ntt_din_0(din0[d]), .ntt_din_1(din1[d]), .ntt_dout_0(dout0), .ntt_dout_1(dout1),
      .err(err[d]));
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: the coefficient array as the host sees it, plus the sequence phase
  int ph, mk, mj;
  bit fin_p, done_m, err_m, e1v, e2v;
  logic [63:0] mem [N];
  bit known [N];
  logic [63:0] e1a, e1b, e2a, e2b;
  task automatic m_reset();
    ph = M_IDLE; mk = 0; mj = 0; fin_p = 0; done_m = 0; err_m = 0;
    e1v = 1; e2v = 1; e1a = '0; e1b = '0; e2a = '0; e2b = '0;
  endtask
  task automatic m_step();
    int ra, wa;
    bit rise;
    ra = int'(raddr[2:0]);
    wa = int'(waddr[2:0]);
    rise = ntt_finish && !fin_p;
    e2v = e1v; e2a = e1a; e2b = e1b;
    e1v = known[ra] && known[ra + H]; e1a = mem[ra]; e1b = mem[ra + H];
    if (CHK && ((ntt_wea && ph != M_RUN) || (ld_valid && ph >= M_RUN) || (rise && ph != M_RUN))) err_m = 1;
    done_m = 0;
    case (ph)
      M_IDLE: if (go) begin ph = M_LOAD; mk = 0; end
      M_LOAD: if (ld_valid) begin
        mem[mk] = ld_data; known[mk] = 1;
        if (mk == N - 1) ph = M_RUN; else mk++;
      end
      M_RUN: begin
        if (ntt_wea) begin
          mem[wa] = dout0; mem[wa + H] = dout1; known[wa] = 1; known[wa + H] = 1;
        end
        if (rise) begin ph = M_UNLOAD; mj = 0; end
      end
      default: if (ul_ready) begin
        if (mj == N - 1) begin ph = M_IDLE; done_m = 1; end else mj++;
      end
    endcase
    fin_p = ntt_finish;
  endtask
  initial begin
    for (int i = 0; i < N; i++) known[i] = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset(); else m_step();
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("reset_ctl", 64'({ld_ready[i], ul_valid[i], busy[i], start[i], done[i], err[i]}), 64'(0));
        chk("reset_din", din0[i] | din1[i], 64'(0));
      end else begin
        chk("ctl", 64'({ld_ready[i], ul_valid[i], busy[i], start[i], done[i], err[i]}),
            64'({ph == M_LOAD, ph == M_UNLOAD, ph != M_IDLE, ph == M_RUN, done_m, err_m}));
        if (ph == M_UNLOAD) chk("ul_data", ul_data[i], mem[mj]);
      end
    end
    if (rst_n && e1v) begin
      chk("din_d1", {din0[0] ^ e1a} | {din1[0] ^ e1b}, 64'(0));
    end
    if (rst_n && e2v) begin
      chk("din_d2", {din0[1] ^ e2a} | {din1[1] ^ e2b}, 64'(0));
    end
    if (rst_n && done[0]) done_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int base, input bit gaps);
    go = 1; tick(); go = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps && i % 3 == 1) begin ld_valid = 0; tick(); end
      ld_valid = 1; ld_data = 64'(base + i); tick();
    end
    ld_valid = 0;
  endtask
  task automatic unload(input bit rnd);
    got.delete();
    for (int c = 0; c < 400 && got.size() < N; c++) begin
      ul_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ul_valid[0] && ul_ready) got.push_back(ul_data[0]);
      tick();
    end
    ul_ready = 0;
    chk("unload_beats", 64'(got.size()), 64'(N));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    chk("reset_busy", 64'(busy[0]), 64'(0));
    chk("reset_din0", din0[0], 64'(0));
    rst_n = 1; tick();
    load(0, 1);
    chk("run_start", 64'({start[0], start[1]}), 64'(3));
    for (int a = 0; a < H; a++) begin
      raddr = {(a % 2 == 1) ? 7'h7f : 7'h00, 3'(a)};
      tick();
      chk("rd1_b0", din0[0], 64'(a));
      chk("rd1_b1", din1[0], 64'(a + 8));
      if (a > 0) chk("rd2_b0", din0[1], 64'(a - 1));
    end
    tick();
    chk("rd2_last", din1[1], 64'(15));
    raddr = 3; waddr = 3; ntt_wea = 1; dout0 = 64'hAAAA; dout1 = 64'hBBBB;
    tick();
    ntt_wea = 0;
    chk("rw_old", din0[0], 64'(3));
    tick();
    chk("rw_new0", din0[0], 64'hAAAA);
    chk("rw_new1", din1[0], 64'hBBBB);
    for (int a = 0; a < H; a++) begin
      waddr = 10'(a); ntt_wea = 1; dout0 = 64'(a + 1); dout1 = 64'(a + 9); tick();
    end
    ntt_wea = 0;
    repeat (3) tick();
    chk("still_run", 64'(start[0]), 64'(1));
    done_cnt = 0;
    ntt_finish = 1; tick(); ntt_finish = 0;
    chk("fin_start", 64'(start[0]), 64'(0));
    chk("fin_ulv", 64'(ul_valid[0]), 64'(1));
    unload(1);
    for (int i = 0; i < N; i++) chk("unload1", got[i], 64'(i + 1));
    repeat (2) tick();
    chk("done1", 64'(done_cnt), 64'(1));
    ntt_finish = 1; tick();
    load(100, 0);
    repeat (5) tick();
    chk("level_fin", 64'({busy[0], start[0], busy[1], start[1]}), 64'hF);
    #1 rst_n = 0;
    #1;
    chk("async_rst", 64'({busy[0], start[0], busy[1], start[1]}), 64'(0));
    ntt_finish = 0;
    repeat (2) tick();
    rst_n = 1; tick();
    done_cnt = 0;
    load(200, 0);
    ntt_finish = 1; tick(); ntt_finish = 0;
    unload(0);
    for (int i = 0; i < N; i++) chk("unload3", got[i], 64'(200 + i));
    repeat (2) tick();
    chk("done3", 64'(done_cnt), 64'(1));
    waddr = 3; dout0 = 64'hDEAD; dout1 = 64'hBEEF; ntt_wea = 1; tick(); ntt_wea = 0;
    ld_valid = 1; ld_data = 64'h5555; tick(); ld_valid = 0;
    repeat (3) tick();
    chk("err_sticky", 64'({err[0], err[1]}), 64'({CHK, CHK}));
    raddr = 3; tick();
    chk("idle_mem0", din0[0], 64'(203));
    chk("idle_mem1", din1[0], 64'(211));
    #1 rst_n = 0; #1;
    chk("err_clr", 64'(err[0]), 64'(0));
    tick(); rst_n = 1; repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
